// File: rtl/miner_nonce_dispatcher_if.sv
// Handshake bundle between the job controller / hashing lanes and miner_nonce_dispatcher.
// master drives range control and lane readiness; slave is the dispatcher.
interface miner_nonce_dispatcher_if #(
   parameter int CORES      = 4,
   parameter int NONCE_BITS = 32
);
   logic                        clear;
   logic                        load;
   logic [NONCE_BITS-1:0]       start_nonce;
   logic [NONCE_BITS-1:0]       end_nonce;
   logic                        enable;
   logic [CORES-1:0]            core_ready;
   logic [CORES-1:0]            nonce_valid;
   logic [CORES*NONCE_BITS-1:0] nonce_out;
   logic                        busy;
   logic                        done;

   modport master (
      output clear, load, start_nonce, end_nonce, enable, core_ready,
      input  nonce_valid, nonce_out, busy, done
   );

   modport slave (
      input  clear, load, start_nonce, end_nonce, enable, core_ready,
      output nonce_valid, nonce_out, busy, done
   );
endinterface

// File: rtl/miner_nonce_dispatcher.sv
// Hands out an inclusive nonce range [start, end] in ascending order across CORES lanes.
// Optional MINER_NONCE_WRAP_EN: on exhaustion restart from start (done pulses) instead of stopping in DONE.
module miner_nonce_dispatcher #(
   parameter int CORES      = 4,
   parameter int NONCE_BITS = 32
) (
   input logic                     clk,
   input logic                     n_rst,
   miner_nonce_dispatcher_if.slave bus
);
   // One extra bit so end = all-ones is reachable without wrapping next_nonce.
   localparam int W = NONCE_BITS + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_p0, state_d;
   logic [W-1:0]          next_p0, next_d;
   logic [W-1:0]          end_p0, end_d;
   logic [CORES-1:0]      vld_p0, vld_d;
   logic [NONCE_BITS-1:0] lane_p0 [CORES];
   logic [NONCE_BITS-1:0] lane_d  [CORES];
`ifdef MINER_NONCE_WRAP_EN
   logic [W-1:0]          start_p0, start_d;
   logic                  wrap_p0, wrap_d;
`endif

   function automatic logic in_range(input logic [W-1:0] val, input logic [W-1:0] last);
      return val <= last;
   endfunction

   always_comb begin
      logic [W-1:0] cnt;
      logic [W-1:0] cand;
      state_d = state_p0;
      next_d  = next_p0;
      end_d   = end_p0;
      vld_d   = vld_p0;
      cnt     = '0;
      cand    = '0;
      for (int i = 0; i < CORES; i++) lane_d[i] = lane_p0[i];
`ifdef MINER_NONCE_WRAP_EN
      start_d = start_p0;
      wrap_d  = 1'b0;
`endif
      if (bus.clear) begin
         state_d = IDLE;
         vld_d   = '0;
      end else if (bus.load) begin
         end_d = {1'b0, bus.end_nonce};
         vld_d = '0;
`ifdef MINER_NONCE_WRAP_EN
         start_d = {1'b0, bus.start_nonce};
`endif
         for (int i = 0; i < CORES; i++) begin
            cand = {1'b0, bus.start_nonce} + W'(i);
            if (in_range(cand, end_d)) begin
               lane_d[i] = cand[NONCE_BITS-1:0];
               vld_d[i]  = 1'b1;
               cnt       = cnt + W'(1);
            end
         end
         next_d  = {1'b0, bus.start_nonce} + cnt;
         state_d = in_range({1'b0, bus.start_nonce}, end_d) ? RUN : DONE;
      end else if (state_p0 == RUN) begin
         // Served lanes take consecutive values; once past end every later lane goes empty.
         for (int i = 0; i < CORES; i++) begin
            if (!vld_p0[i] || bus.core_ready[i]) begin
               if (bus.enable) begin
                  cand = next_p0 + cnt;
                  if (in_range(cand, end_p0)) begin
                     lane_d[i] = cand[NONCE_BITS-1:0];
                     vld_d[i]  = 1'b1;
                     cnt       = cnt + W'(1);
                  end else begin
                     vld_d[i] = 1'b0;
                  end
               end else begin
                  vld_d[i] = 1'b0;
               end
            end
         end
         next_d = next_p0 + cnt;
         if (!in_range(next_d, end_p0) && (vld_d == '0)) begin
`ifdef MINER_NONCE_WRAP_EN
            next_d = start_p0;
            wrap_d = 1'b1;
`else
            state_d = DONE;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_p0 <= IDLE;
         next_p0  <= '0;
         end_p0   <= '0;
         vld_p0   <= '0;
         for (int i = 0; i < CORES; i++) lane_p0[i] <= '0;
`ifdef MINER_NONCE_WRAP_EN
         start_p0 <= '0;
         wrap_p0  <= 1'b0;
`endif
      end else begin
         state_p0 <= state_d;
         next_p0  <= next_d;
         end_p0   <= end_d;
         vld_p0   <= vld_d;
         for (int i = 0; i < CORES; i++) lane_p0[i] <= lane_d[i];
`ifdef MINER_NONCE_WRAP_EN
         start_p0 <= start_d;
         wrap_p0  <= wrap_d;
`endif
      end
   end

   for (genvar g = 0; g < CORES; g++) begin : g_lane
      assign bus.nonce_out[g*NONCE_BITS +: NONCE_BITS] = lane_p0[g];
   end

   assign bus.nonce_valid = vld_p0;
   assign bus.busy        = (state_p0 == RUN);
`ifdef MINER_NONCE_WRAP_EN
   assign bus.done        = (state_p0 == DONE) | wrap_p0;
`else
   assign bus.done        = (state_p0 == DONE);
`endif
endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// Scoreboard bench for miner_nonce_dispatcher (CORES=4, NONCE_BITS=8): every newly issued nonce is
// popped against the ascending range queue; held lanes must keep their value.
module tb_miner_nonce_dispatcher;
   localparam int NC = 4;
   localparam int NB = 8;

   logic clk = 1'b0;
   logic n_rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   miner_nonce_dispatcher_if #(.CORES(NC), .NONCE_BITS(NB)) bus ();

   miner_nonce_dispatcher #(.CORES(NC), .NONCE_BITS(NB)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [NB-1:0] s, input logic [NB-1:0] e);
      bus.start_nonce = s;
      bus.end_nonce   = e;
      bus.load        = 1'b1;
      step(1);
      bus.load        = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!bus.done && n < budget) begin
         step(1);
         n++;
      end
      chk("done_reached", 64'(bus.done), 64'h1);
   endtask

   // Scoreboard: the range is queued when a load is taken, and each fresh lane value pops it.
   logic [NB-1:0] exp_q [$];
   logic [NC-1:0] p_vld, p_rdy;
   logic          p_load, p_clear;
   logic [NB-1:0] p_s, p_e;
   logic [NB-1:0] p_lane [NC];
`ifdef MINER_NONCE_WRAP_EN
   logic [NB-1:0] ld_s, ld_e;
`endif

   always @(negedge clk) begin
      if (!n_rst) begin
         exp_q.delete();
         p_vld   = '0;
         p_rdy   = '0;
         p_load  = 1'b0;
         p_clear = 1'b0;
      end else begin
         if (p_clear) begin
            exp_q.delete();
         end else if (p_load) begin
            exp_q.delete();
`ifdef MINER_NONCE_WRAP_EN
            ld_s = p_s;
            ld_e = p_e;
`endif
            for (int v = int'(p_s); v <= int'(p_e); v++) exp_q.push_back(NB'(v));
         end
`ifdef MINER_NONCE_WRAP_EN
         else if (bus.done && bus.busy) begin
            for (int v = int'(ld_s); v <= int'(ld_e); v++) exp_q.push_back(NB'(v));
         end
`endif
         for (int i = 0; i < NC; i++) begin
            logic [NB-1:0] cur;
            cur = bus.nonce_out[i*NB +: NB];
            if (bus.nonce_valid[i] && (!p_vld[i] || p_rdy[i] || p_load)) begin
               chk("issue_avail", 64'(exp_q.size() != 0), 64'h1);
               if (exp_q.size() != 0) chk("issue_seq", 64'(cur), 64'(exp_q.pop_front()));
            end else if (p_vld[i] && !p_rdy[i] && !p_load && !p_clear) begin
               chk("hold_vld", 64'(bus.nonce_valid[i]), 64'h1);
               chk("hold_val", 64'(cur), 64'(p_lane[i]));
            end
         end
         p_vld   = bus.nonce_valid;
         p_rdy   = bus.core_ready;
         p_load  = bus.load;
         p_clear = bus.clear;
         p_s     = bus.start_nonce;
         p_e     = bus.end_nonce;
         for (int i = 0; i < NC; i++) p_lane[i] = bus.nonce_out[i*NB +: NB];
      end
   end

   initial begin
      n_rst           = 1'b0;
      bus.clear       = 1'b0;
      bus.load        = 1'b0;
      bus.start_nonce = '0;
      bus.end_nonce   = '0;
      bus.enable      = 1'b1;
      bus.core_ready  = '0;
      #12;
      chk("rst_vld",  64'(bus.nonce_valid), 64'h0);
      chk("rst_out",  64'(bus.nonce_out),   64'h0);
      chk("rst_busy", 64'(bus.busy),        64'h0);
      chk("rst_done", 64'(bus.done),        64'h0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      step(1);

`ifdef MINER_NONCE_WRAP_EN
      begin
         int dc;
         dc = 0;
         bus.core_ready = '1;
         do_load(8'h00, 8'h05);
         chk("wrap_first", 64'(bus.nonce_out), 64'h03020100);
         for (int k = 0; k < 6; k++) begin
            dc += int'(bus.done);
            chk("wrap_busy", 64'(bus.busy), 64'h1);
            step(1);
         end
         chk("wrap_pulses", 64'(dc), 64'h2);
         bus.clear = 1'b1;
         step(1);
         bus.clear = 1'b0;
      end
`else
      // Full range, all lanes ready.
      bus.core_ready = '1;
      do_load(8'h10, 8'h1F);
      chk("t1_vld0", 64'(bus.nonce_valid), 64'hF);
      chk("t1_out0", 64'(bus.nonce_out), 64'h13121110);
      step(1);
      chk("t1_out1", 64'(bus.nonce_out), 64'h17161514);
      step(2);
      chk("t1_out3", 64'(bus.nonce_out), 64'h1F1E1D1C);
      chk("t1_busy", 64'(bus.busy), 64'h1);
      chk("t1_ndone", 64'(bus.done), 64'h0);
      step(1);
      chk("t1_done", 64'(bus.done), 64'h1);
      chk("t1_idle", 64'(bus.busy), 64'h0);
      chk("t1_empty", 64'(bus.nonce_valid), 64'h0);
      chk("t1_nogap", 64'(exp_q.size()), 64'h0);
      step(1);
      chk("t1_level", 64'(bus.done), 64'h1);

      // Lanes 1 and 3 stalled, 0 and 2 consume the rest.
      bus.core_ready = 4'b0101;
      do_load(8'h10, 8'h1F);
      chk("t2_ndone", 64'(bus.done), 64'h0);
      step(7);
      chk("t2_vld", 64'(bus.nonce_valid), 64'hA);
      chk("t2_l1", 64'(bus.nonce_out[15:8]), 64'h11);
      chk("t2_l3", 64'(bus.nonce_out[31:24]), 64'h13);
      chk("t2_busy", 64'(bus.busy), 64'h1);
      bus.core_ready = '1;
      step(1);
      chk("t2_done", 64'(bus.done), 64'h1);
      chk("t2_nogap", 64'(exp_q.size()), 64'h0);

      // Top-of-range boundary.
      do_load(8'hFD, 8'hFF);
      chk("t3_vld", 64'(bus.nonce_valid), 64'h7);
      chk("t3_out", 64'(bus.nonce_out[23:0]), 64'hFFFEFD);
      step(1);
      chk("t3_done", 64'(bus.done), 64'h1);
      chk("t3_empty", 64'(bus.nonce_valid), 64'h0);
      step(2);
      chk("t3_stay", 64'(bus.nonce_valid), 64'h0);

      // Pause and resume.
      do_load(8'h40, 8'h4F);
      bus.enable = 1'b0;
      step(1);
      chk("t4_drain", 64'(bus.nonce_valid), 64'h0);
      chk("t4_busy", 64'(bus.busy), 64'h1);
      step(2);
      chk("t4_paused", 64'(bus.nonce_valid), 64'h0);
      bus.enable = 1'b1;
      step(1);
      chk("t4_resume", 64'(bus.nonce_out), 64'h47464544);
      chk("t4_rvld", 64'(bus.nonce_valid), 64'hF);
      wait_done(50);
      chk("t4_nogap", 64'(exp_q.size()), 64'h0);
`endif

      // clear beats load, then an empty range, then async reset.
      bus.core_ready = '1;
      do_load(8'h50, 8'h7F);
      step(1);
      bus.clear = 1'b1;
      bus.load  = 1'b1;
      step(1);
      bus.clear = 1'b0;
      bus.load  = 1'b0;
      chk("t5_clr_vld", 64'(bus.nonce_valid), 64'h0);
      chk("t5_clr_busy", 64'(bus.busy), 64'h0);
      chk("t5_clr_done", 64'(bus.done), 64'h0);
      step(2);
      chk("t5_idle_vld", 64'(bus.nonce_valid), 64'h0);
      do_load(8'h20, 8'h1F);
      chk("t5_inv_done", 64'(bus.done), 64'h1);
      chk("t5_inv_busy", 64'(bus.busy), 64'h0);
      chk("t5_inv_vld", 64'(bus.nonce_valid), 64'h0);
      step(2);
      chk("t5_inv_hold", 64'(bus.done), 64'h1);
      do_load(8'h30, 8'h3F);
      step(1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("t5_ar_vld", 64'(bus.nonce_valid), 64'h0);
      chk("t5_ar_out", 64'(bus.nonce_out), 64'h0);
      chk("t5_ar_busy", 64'(bus.busy), 64'h0);
      chk("t5_ar_done", 64'(bus.done), 64'h0);
      step(2);
      n_rst = 1'b1;
      step(1);
      do_load(8'h60, 8'h67);
      chk("t5_re_out0", 64'(bus.nonce_out), 64'h63626160);
      step(1);
      chk("t5_re_out1", 64'(bus.nonce_out), 64'h67666564);
      bus.clear = 1'b1;
      step(1);
      bus.clear = 1'b0;
      step(1);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
